node_seq: RTL and testbench
===========================

// Module: node_seq
// PURPOSE
// - Per-node sweep sequencer; time-multiplexes SLOTS replicas through one shared random/distance/metropolis datapath.
// - Per slot: draws randoms, requests a delta distance, applies a temperature-scaled metropolis test and updates the slot total.
// - Pulses a commit for the ordering-exchange logic.
// - At sweep end, optionally runs an even/odd adjacent-slot replica exchange pass.
// PARAMETERS
// - SLOTS  4   replicas per node (2..16)
// - DW     24  signed delta-distance width
// - TW     24  unsigned total-distance width (TW >= DW-1)
// - RW     32  r_metropolis width (>= 8)
// PORTS
// - clk           in   1       clock
// - reset         in   1       asynchronous active-low reset (0 = reset)
// - start         in   1       sweep request pulse; sampled in IDLE only
// - busy          out  1       high from the cycle after start until done
// - done          out  1       1-cycle pulse at sweep end
// - cfg_we        in   1       writes total[cfg_slot] and shift[cfg_slot]; ignored while busy
// - cfg_slot      in   $clog2(SLOTS)  config slot index
// - cfg_total     in   TW      initial total distance
// - cfg_shift     in   4       temperature shift (larger = colder)
// - rnd_run       out  1       1-cycle pulse to random generator
// - r_metropolis  in   RW      valid the cycle after rnd_run, held stable
// - dist_start    out  1       1-cycle pulse, delta request
// - dist_slot     out  $clog2(SLOTS)  slot under evaluation, stable while busy in slot
// - dist_done     in   1       delta valid strobe
// - delta         in   DW      signed delta distance, valid with dist_done
// - commit_valid  out  1       1-cycle pulse per slot
// - commit_slot   out  $clog2(SLOTS)  slot of commit
// - commit_accept out  1       metropolis result, qualified by commit_valid
// - xchg_valid    out  1       1-cycle pulse per swapped pair
// - xchg_slot     out  $clog2(SLOTS)  lower slot index of swapped pair
// - sweep_cnt     out  16      completed sweeps, wraps at 16'hFFFF -> 0
// - rd_slot       in   $clog2(SLOTS)  total readback index
// - rd_total      out  TW      total[rd_slot], combinational
// BEHAVIOUR
// - Reset (async, any state)
//   - FSM -> IDLE.
//   - All outputs 0; sweep_cnt, slot counter, totals and shifts cleared.
//   - In-flight sweep abandoned with no commit.
// - States: IDLE -> RAND -> DIST -> METRO -> COMMIT -> (RAND next slot | EXCH | DONE) -> IDLE.
// - IDLE: on start, slot=0 -> RAND. start while busy is ignored.
// - RAND: rnd_run=1 for 1 cycle -> DIST.
// - DIST
//   - dist_start=1 on the entry cycle only; waits indefinitely for dist_done.
//   - Captures delta on dist_done; dist_done outside DIST is ignored.
//   - dist_done in the entry cycle is accepted -> METRO.
// - METRO (1 cycle): m = r_metropolis[RW-1:RW-8] (zero-extended); d = delta >>> shift[slot] (arithmetic).
//   - accept = (delta <= 0) || (d < m). Registered -> COMMIT.
// - COMMIT (1 cycle)
//   - Outputs: commit_valid=1, commit_slot=slot, commit_accept.
//   - If accepted: total[slot] += sign-extended delta, saturating at 0 and 2^TW-1.
//   - Last slot -> EXCH if enabled, else DONE; otherwise slot+1 -> RAND.
// - Minimum per-slot latency: 4 cycles + distance latency. Total update is visible on rd_total the cycle after COMMIT.
// - DONE: done=1 for 1 cycle, sweep_cnt+1, busy drops the same cycle -> IDLE.
// - Back-to-back sweeps: start in the cycle after done is accepted.
// CONFIGURATION
// - NODE_SEQ_EXCHANGE_EN defined: EXCH state present.
//   - parity = sweep_cnt[0] (pre-increment).
//   - Pairs (p, p+1) for p = parity, parity+2, ... with p+1 < SLOTS, one pair per cycle.
//   - If total[p+1] < total[p]: swap the two totals; xchg_valid=1, xchg_slot=p. Shifts stay with their slots.
//   - Pass length: ceil((SLOTS-parity-1)/2) cycles (0 cycles = direct to DONE).
// - NODE_SEQ_EXCHANGE_EN undefined: no EXCH state; COMMIT of the last slot -> DONE; xchg_valid/xchg_slot tied to 0.
// TESTING
// - Config totals {100,200,300,400}, shifts 0; start; delta=-5 on all slots -> 4 commits accept=1, totals {95,195,295,395}, done, sweep_cnt=1.
// - shift=2, delta=+40, r_metropolis[31:24]=8'h0A -> d=10 not < 10, accept=0, total unchanged; with r top byte 8'h0B -> accept=1, total +40.
// - total=3, delta=-10 accepted -> total saturates to 0; total=2^TW-2, delta=+5, r=max -> saturates to 2^TW-1.
// - EXCHANGE_EN, sweep_cnt=0, SLOTS=4, totals {50,40,30,60} after commits (delta=0) -> pairs (0,1),(2,3): one xchg_valid slot 0, totals {40,50,30,60}; next sweep parity 1 pair (1,2) -> swap, xchg_slot=1, totals {40,30,50,60}.
// - Assert reset mid-DIST with dist_done pending -> all outputs 0 immediately, no commit; start after release runs a clean sweep from slot 0.
// - start asserted while busy and cfg_we while busy -> no effect; dist_done pulsed in IDLE -> ignored.

Source files
------------

// File: rtl/node_seq.sv
// node_seq: per-node sweep sequencer sharing one random/distance/metropolis datapath across SLOTS replicas.
// Define NODE_SEQ_EXCHANGE_EN to add the even/odd adjacent-slot replica exchange pass at sweep end.
module node_seq #(
  parameter int SLOTS = 4,
  parameter int DW    = 24,
  parameter int TW    = 24,
  parameter int RW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     cfg_we,
  input  logic [$clog2(SLOTS)-1:0] cfg_slot,
  input  logic [TW-1:0]            cfg_total,
  input  logic [3:0]               cfg_shift,
  output logic                     rnd_run,
  input  logic [RW-1:0]            r_metropolis,
  output logic                     dist_start,
  output logic [$clog2(SLOTS)-1:0] dist_slot,
  input  logic                     dist_done,
  input  logic signed [DW-1:0]     delta,
  output logic                     commit_valid,
  output logic [$clog2(SLOTS)-1:0] commit_slot,
  output logic                     commit_accept,
  output logic                     xchg_valid,
  output logic [$clog2(SLOTS)-1:0] xchg_slot,
  output logic [15:0]              sweep_cnt,
  input  logic [$clog2(SLOTS)-1:0] rd_slot,
  output logic [TW-1:0]            rd_total
);

  localparam int SIW = $clog2(SLOTS);
  localparam int CW  = ((DW > 8) ? DW : 8) + 1;
  localparam int SW  = TW + 2;

  // state    | meaning
  // S_IDLE   | waiting for start, config writes allowed
  // S_RAND   | pulse rnd_run for the current slot
  // S_DIST   | request delta, wait for dist_done
  // S_METRO  | evaluate metropolis test, register accept
  // S_COMMIT | publish commit, apply saturating total update
  // S_EXCH   | one adjacent-pair compare/swap per cycle (exchange builds only)
  // S_DONE   | done pulse, sweep counter increment
  typedef enum logic [2:0] {
    S_IDLE,
    S_RAND,
    S_DIST,
    S_METRO,
    S_COMMIT,
`ifdef NODE_SEQ_EXCHANGE_EN
    S_EXCH,
`endif
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SIW-1:0]       slot_q, slot_d;
  logic signed [DW-1:0] delta_q, delta_d;
  logic                 accept_q, accept_d;
  logic                 dist_entry_q, dist_entry_d;
  logic [15:0]          sweep_q, sweep_d;
  logic [TW-1:0]        total_q [SLOTS];
  logic [TW-1:0]        total_d [SLOTS];
  logic [3:0]           shift_q [SLOTS];
  logic [3:0]           shift_d [SLOTS];

  logic                 last_slot;
  logic [7:0]           m_byte;
  logic signed [DW-1:0] d_shift;
  logic signed [CW-1:0] d_cmp;
  logic signed [CW-1:0] m_cmp;
  logic                 metro_ok;
  logic signed [SW-1:0] sum;
  logic [TW-1:0]        sat_total;
  logic                 unused_r;

  assign last_slot = (slot_q == SIW'(SLOTS - 1));

  // Only the top byte of the random word feeds the test.
  assign m_byte   = r_metropolis[RW-1:RW-8];
  assign unused_r = ^r_metropolis;

  assign d_shift  = delta_q >>> shift_q[slot_q];
  assign d_cmp    = CW'(d_shift);
  assign m_cmp    = $signed(CW'(m_byte));
  assign metro_ok = delta_q[DW-1] || (delta_q == '0) || (d_cmp < m_cmp);

  // Two guard bits catch both underflow below 0 and overflow past 2^TW-1.
  assign sum = $signed({2'b00, total_q[slot_q]}) + SW'(delta_q);

  always_comb begin
    sat_total = sum[TW-1:0];
    if (sum[SW-1]) begin
      sat_total = '0;
    end else if (sum[SW-2]) begin
      sat_total = '1;
    end
  end

`ifdef NODE_SEQ_EXCHANGE_EN
  logic [SIW-1:0] xp_q, xp_d, xp_hi;
  logic           do_swap;

  assign xp_hi      = xp_q + SIW'(1);
  assign do_swap    = (state_q == S_EXCH) && (total_q[xp_hi] < total_q[xp_q]);
  assign xchg_valid = do_swap;
  assign xchg_slot  = do_swap ? xp_q : '0;
`else
  assign xchg_valid = 1'b0;
  assign xchg_slot  = '0;
`endif

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    delta_d      = delta_q;
    accept_d     = accept_q;
    dist_entry_d = 1'b0;
    sweep_d      = sweep_q;
    total_d      = total_q;
    shift_d      = shift_q;
`ifdef NODE_SEQ_EXCHANGE_EN
    xp_d         = xp_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          slot_d  = '0;
          state_d = S_RAND;
        end
      end
      S_RAND: begin
        dist_entry_d = 1'b1;
        state_d      = S_DIST;
      end
      S_DIST: begin
        if (dist_done) begin
          delta_d = delta;
          state_d = S_METRO;
        end
      end
      S_METRO: begin
        accept_d = metro_ok;
        state_d  = S_COMMIT;
      end
      S_COMMIT: begin
        if (accept_q) begin
          total_d[slot_q] = sat_total;
        end
        if (last_slot) begin
`ifdef NODE_SEQ_EXCHANGE_EN
          // Pass parity alternates with the pre-increment sweep count.
          if (int'(sweep_q[0]) + 1 < SLOTS) begin
            xp_d    = SIW'(sweep_q[0]);
            state_d = S_EXCH;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          slot_d  = slot_q + SIW'(1);
          state_d = S_RAND;
        end
      end
`ifdef NODE_SEQ_EXCHANGE_EN
      S_EXCH: begin
        if (do_swap) begin
          total_d[xp_q]  = total_q[xp_hi];
          total_d[xp_hi] = total_q[xp_q];
        end
        if (int'(xp_q) + 3 < SLOTS) begin
          xp_d = xp_q + SIW'(2);
        end else begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        sweep_d = sweep_q + 16'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cfg_we && !busy) begin
      total_d[cfg_slot] = cfg_total;
      shift_d[cfg_slot] = cfg_shift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      delta_q      <= '0;
      accept_q     <= 1'b0;
      dist_entry_q <= 1'b0;
      sweep_q      <= '0;
      total_q      <= '{default: '0};
      shift_q      <= '{default: '0};
`ifdef NODE_SEQ_EXCHANGE_EN
      xp_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      delta_q      <= delta_d;
      accept_q     <= accept_d;
      dist_entry_q <= dist_entry_d;
      sweep_q      <= sweep_d;
      total_q      <= total_d;
      shift_q      <= shift_d;
`ifdef NODE_SEQ_EXCHANGE_EN
      xp_q         <= xp_d;
`endif
    end
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign rnd_run       = (state_q == S_RAND);
  assign dist_start    = (state_q == S_DIST) && dist_entry_q;
  assign dist_slot     = slot_q;
  assign commit_valid  = (state_q == S_COMMIT);
  assign commit_slot   = slot_q;
  assign commit_accept = (state_q == S_COMMIT) && accept_q;
  assign sweep_cnt     = sweep_q;
  assign rd_total      = (int'(rd_slot) < SLOTS) ? total_q[rd_slot] : '0;

endmodule

// File: tb/tb_node_seq.sv
// Scoreboard bench for node_seq: commits/exchanges checked by a monitor, totals via rd_total.
module tb_node_seq;
  localparam int SLOTS = 4;
  localparam int DW    = 24;
  localparam int TW    = 24;
  localparam int RW    = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 cfg_we;
  logic [1:0]           cfg_slot;
  logic [TW-1:0]        cfg_total;
  logic [3:0]           cfg_shift;
  logic                 rnd_run;
  logic [RW-1:0]        r_metropolis;
  logic                 dist_start;
  logic [1:0]           dist_slot;
  logic                 dist_done;
  logic signed [DW-1:0] delta;
  logic                 commit_valid;
  logic [1:0]           commit_slot;
  logic                 commit_accept;
  logic                 xchg_valid;
  logic [1:0]           xchg_slot;
  logic [15:0]          sweep_cnt;
  logic [1:0]           rd_slot;
  logic [TW-1:0]        rd_total;

  always #5 clk = ~clk;

  node_seq #(.SLOTS(SLOTS), .DW(DW), .TW(TW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_total(cfg_total), .cfg_shift(cfg_shift),
    .rnd_run(rnd_run), .r_metropolis(r_metropolis),
    .dist_start(dist_start), .dist_slot(dist_slot), .dist_done(dist_done), .delta(delta),
    .commit_valid(commit_valid), .commit_slot(commit_slot), .commit_accept(commit_accept),
    .xchg_valid(xchg_valid), .xchg_slot(xchg_slot), .sweep_cnt(sweep_cnt),
    .rd_slot(rd_slot), .rd_total(rd_total)
  );

  typedef struct packed {
    logic [1:0] slot;
    logic       acc;
  } cmt_t;

  int                   n_vec  = 0;
  int                   n_miss = 0;
  cmt_t                 exp_cmt[$];
  logic [1:0]           exp_x[$];
  cmt_t                 mon_e;
  logic [1:0]           mon_x;
  logic signed [DW-1:0] dval [SLOTS];
  int                   lat  [SLOTS];
  logic                 resp_pend;
  int                   resp_cnt;
  logic [1:0]           resp_slot;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Distance engine model: answers each dist_start after lat[slot] extra cycles.
  initial begin
    dist_done = 1'b0;
    delta     = '0;
    resp_pend = 1'b0;
    resp_cnt  = 0;
    resp_slot = '0;
    forever begin
      @(negedge clk);
      dist_done = 1'b0;
      if (dist_start) begin
        resp_pend = 1'b1;
        resp_slot = dist_slot;
        resp_cnt  = lat[dist_slot];
      end
      if (resp_pend) begin
        if (resp_cnt == 0) begin
          dist_done = 1'b1;
          delta     = dval[resp_slot];
          resp_pend = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a commit or exchange.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (commit_valid) begin
          if (exp_cmt.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected commit: slot %0d accept %0b, none expected", commit_slot, commit_accept);
          end else begin
            mon_e = exp_cmt.pop_front();
            chk("commit slot", 64'(commit_slot), 64'(mon_e.slot));
            chk($sformatf("commit accept slot %0d", mon_e.slot), 64'(commit_accept), 64'(mon_e.acc));
          end
        end
        if (xchg_valid) begin
          if (exp_x.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected xchg: slot %0d, none expected", xchg_slot);
          end else begin
            mon_x = exp_x.pop_front();
            chk("xchg slot", 64'(xchg_slot), 64'(mon_x));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic cfg(input int s, input logic [TW-1:0] t, input logic [3:0] sh);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_slot  = 2'(s);
    cfg_total = t;
    cfg_shift = sh;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic expect_commits(input logic [3:0] acc);
    for (int s = 0; s < SLOTS; s++) exp_cmt.push_back('{slot: 2'(s), acc: acc[s]});
  endtask

  task automatic chk_zero(input string name);
    chk(name, {11'd0, busy, done, rnd_run, dist_start, dist_slot, commit_valid, commit_slot,
               commit_accept, xchg_valid, xchg_slot, sweep_cnt, rd_total}, 64'd0);
  endtask

  task automatic check_totals(input string tag, input logic [TW-1:0] e [SLOTS]);
    for (int s = 0; s < SLOTS; s++) begin
      rd_slot = 2'(s);
      #1;
      chk($sformatf("%s total[%0d]", tag, s), 64'(rd_total), 64'(e[s]));
    end
  endtask

  // Runs one sweep; with poke set, pulses start and cfg_we mid-sweep (both must be ignored).
  task automatic run_sweep(input string tag, input bit poke);
    bit seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after start"}, 64'(busy), 64'd1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (poke && cyc == 4) begin
          start     = 1'b1;
          cfg_we    = 1'b1;
          cfg_slot  = 2'd1;
          cfg_total = 24'd7;
          cfg_shift = 4'hF;
        end else begin
          start  = 1'b0;
          cfg_we = 1'b0;
        end
        @(negedge clk);
      end
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL %s done timeout: no done within 400 cycles", tag);
    end else begin
      chk({tag, " busy low with done"}, 64'(busy), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    bit found;
    reset        = 1'b0;
    start        = 1'b0;
    cfg_we       = 1'b0;
    cfg_slot     = '0;
    cfg_total    = '0;
    cfg_shift    = '0;
    r_metropolis = '0;
    rd_slot      = '0;
    dval         = '{default: '0};
    lat          = '{default: 1};
    repeat (3) @(negedge clk);
    #1 chk_zero("reset outputs");
    @(negedge clk);
    reset = 1'b1;

    // Negative deltas always accept.
    cfg(0, 24'd100, 4'd0); cfg(1, 24'd200, 4'd0); cfg(2, 24'd300, 4'd0); cfg(3, 24'd400, 4'd0);
    dval = '{-24'sd5, -24'sd5, -24'sd5, -24'sd5};
    expect_commits(4'b1111);
    run_sweep("t1", 1'b0);
    check_totals("t1", '{24'd95, 24'd195, 24'd295, 24'd395});
    chk("t1 sweep_cnt", 64'(sweep_cnt), 64'd1);

    // Metropolis boundary: d = 40>>>2 = 10 against m = 10 rejects, m = 11 accepts.
    cfg(0, 24'd100, 4'd2);
    dval = '{24'sd40, 24'sd0, 24'sd0, 24'sd0};
    r_metropolis = 32'h0A00_0000;
    expect_commits(4'b1110);
    run_sweep("t2a", 1'b0);
    check_totals("t2a", '{24'd100, 24'd195, 24'd295, 24'd395});
    r_metropolis = 32'h0B00_0000;
    expect_commits(4'b1111);
    run_sweep("t2b", 1'b0);
    check_totals("t2b", '{24'd140, 24'd195, 24'd295, 24'd395});
    chk("t2 sweep_cnt", 64'(sweep_cnt), 64'd3);

    // Saturation at both ends.
    cfg(0, 24'd3, 4'd0);
    cfg(3, 24'hFF_FFFE, 4'd0);
    dval = '{-24'sd10, 24'sd0, 24'sd0, 24'sd5};
    r_metropolis = 32'hFFFF_FFFF;
    expect_commits(4'b1111);
    run_sweep("t3", 1'b0);
    check_totals("t3", '{24'd0, 24'd195, 24'd295, 24'hFF_FFFF});

    // Mixed accepts, slower distance engine, start/cfg_we pokes while busy.
    lat  = '{3, 3, 3, 3};
    dval = '{24'sd0, 24'sd1, 24'sd2, -24'sd1};
    r_metropolis = 32'h0200_0000;
    expect_commits(4'b1011);
    run_sweep("t4", 1'b1);
    check_totals("t4", '{24'd0, 24'd196, 24'd295, 24'hFF_FFFE});
    chk("t4 sweep_cnt", 64'(sweep_cnt), 64'd5);
    repeat (10) @(negedge clk);
    chk("t4 no restart from busy start", {47'd0, busy, sweep_cnt}, {47'd0, 1'b0, 16'd5});

    // Reset in slot 2 DIST with a response still pending; that dist_done lands in IDLE.
    lat  = '{1, 1, 30, 1};
    dval = '{default: '0};
    exp_cmt.push_back('{slot: 2'd0, acc: 1'b1});
    exp_cmt.push_back('{slot: 2'd1, acc: 1'b1});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      if (dist_start && dist_slot == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL t5 slot 2 dist_start timeout: not seen within 100 cycles");
    end
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    rd_slot = 2'd3;
    #1 chk_zero("t5 outputs in reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5 idle after stray dist_done", {47'd0, busy, sweep_cnt}, 64'd0);
    chk("t5 scoreboard after reset", 64'(exp_cmt.size()), 64'd0);

    // Clean sweeps from slot 0; exchange pass when built in.
    lat  = '{default: 0};
    dval = '{default: '0};
    r_metropolis = '0;
    cfg(0, 24'd50, 4'd0); cfg(1, 24'd40, 4'd0); cfg(2, 24'd30, 4'd0); cfg(3, 24'd60, 4'd0);
    expect_commits(4'b1111);
`ifdef NODE_SEQ_EXCHANGE_EN
    exp_x.push_back(2'd0);
    run_sweep("t6a", 1'b0);
    check_totals("t6a", '{24'd40, 24'd50, 24'd30, 24'd60});
`else
    run_sweep("t6a", 1'b0);
    check_totals("t6a", '{24'd50, 24'd40, 24'd30, 24'd60});
`endif
    chk("t6a sweep_cnt", 64'(sweep_cnt), 64'd1);
    expect_commits(4'b1111);
`ifdef NODE_SEQ_EXCHANGE_EN
    exp_x.push_back(2'd1);
    run_sweep("t6b", 1'b0);
    check_totals("t6b", '{24'd40, 24'd30, 24'd50, 24'd60});
`else
    run_sweep("t6b", 1'b0);
    check_totals("t6b", '{24'd50, 24'd40, 24'd30, 24'd60});
`endif
    chk("t6b sweep_cnt", 64'(sweep_cnt), 64'd2);

    repeat (3) @(negedge clk);
    chk("commit queue drained", 64'(exp_cmt.size()), 64'd0);
    chk("xchg queue drained", 64'(exp_x.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
